// File: rtl/calc_ctrl_gen.sv
// rtl/calc_ctrl_gen.sv - keypad calculator sequencer driving an external add/sub/mul unit over start/done.
// Define CALC_CHAIN_EN to let an operator key in SHOW reuse the shown result as operand A.
module calc_ctrl_gen #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic [3:0]       key_digit,
    input  logic             key_valid,
    input  logic [1:0]       op_sel,
    input  logic             op_valid,
    input  logic             neg_key,
    input  logic             equal_key,
    input  logic             clear_key,
    output logic             exe_start,
    output logic [1:0]       exe_op,
    output logic [WIDTH-1:0] exe_a,
    output logic [WIDTH-1:0] exe_b,
    input  logic             exe_done,
    input  logic [WIDTH-1:0] exe_result,
    input  logic             exe_ovf,
    output logic [WIDTH-1:0] display_value,
    output logic             busy,
    output logic             complete,
    output logic             overflow,
    output logic             error,
    output logic             entry_err
);
    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH+3:0] MAX_MAG = {5'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {ENTER_A, ENTER_B, ISSUE, WAIT, SHOW} state_t;
    state_t state, next_state;

    logic [WIDTH-1:0] mag_a, mag_b, result_q, val_a, val_b, cur_mag;
    logic             sign_a, sign_b;
    logic [DW-1:0]    dig_a, dig_b, cur_dig;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH+3:0] cur_w, new_mag;
    logic in_entry, sel_equal, sel_op, sel_neg, sel_digit;
    logic op_acc, neg_acc, eq_acc, digit_ok, reject, dig_acc, dig_rej;
    logic done_hit, timeout_hit, chain_load, key_accept;

    assign val_a = sign_a ? -mag_a : mag_a;
    assign val_b = sign_b ? -mag_b : mag_b;

    // Only the highest-priority strobe present is considered, even if that key is then ignored.
    assign sel_equal = !clear_key && equal_key;
    assign sel_op    = !clear_key && !equal_key && op_valid;
    assign sel_neg   = !clear_key && !equal_key && !op_valid && neg_key;
    assign sel_digit = !clear_key && !equal_key && !op_valid && !neg_key && key_valid;

    assign in_entry = (state == ENTER_A) || (state == ENTER_B);
    assign cur_mag  = (state == ENTER_B) ? mag_b : mag_a;
    assign cur_dig  = (state == ENTER_B) ? dig_b : dig_a;
    assign cur_w    = {4'b0, cur_mag};
    assign new_mag  = (cur_w << 3) + (cur_w << 1) + {{WIDTH{1'b0}}, key_digit};
    // A zero magnitude after the digit means a leading zero, which does not use up a digit slot.
    assign reject   = ((new_mag != '0) && (cur_dig >= DW'(MAX_DIGITS))) || (new_mag > MAX_MAG);

    assign op_acc   = sel_op && (op_sel != 2'b11) && in_entry;
    assign neg_acc  = sel_neg && in_entry;
    assign eq_acc   = sel_equal && (state == ENTER_B);
    assign digit_ok = sel_digit && (key_digit <= 4'd9);
    assign dig_acc  = digit_ok && ((state == SHOW) || (in_entry && !reject));
    assign dig_rej  = digit_ok && in_entry && reject;

    assign done_hit    = ((state == ISSUE) || (state == WAIT)) && exe_done;
    assign timeout_hit = (state == WAIT) && !exe_done && (cnt == CW'(TIMEOUT - 1));

`ifdef CALC_CHAIN_EN
    logic [WIDTH-1:0] abs_res;
    assign abs_res    = result_q[WIDTH-1] ? -result_q : result_q;
    assign chain_load = (state == SHOW) && sel_op && (op_sel != 2'b11);
`else
    assign chain_load = 1'b0;
`endif

    assign key_accept = chain_load || op_acc || neg_acc || eq_acc || dig_acc;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) state <= ENTER_A;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ENTER_A: if (op_acc) next_state = ENTER_B;
            ENTER_B: if (eq_acc) next_state = ISSUE;
            ISSUE:   next_state = exe_done ? SHOW : WAIT;
            WAIT:    if (exe_done || timeout_hit) next_state = SHOW;
            SHOW: begin
                if (digit_ok)        next_state = ENTER_A;
                else if (chain_load) next_state = ENTER_B;
            end
            default: next_state = ENTER_A;
        endcase
        if (clear_key) next_state = ENTER_A;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            mag_a <= '0; mag_b <= '0; sign_a <= 1'b0; sign_b <= 1'b0;
            dig_a <= '0; dig_b <= '0; op_q <= 2'b00; result_q <= '0; cnt <= '0;
            overflow <= 1'b0; error <= 1'b0; entry_err <= 1'b0;
        end else begin
            entry_err <= 1'b0;
            cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (clear_key) begin
                mag_a <= '0; mag_b <= '0; sign_a <= 1'b0; sign_b <= 1'b0;
                dig_a <= '0; dig_b <= '0; op_q <= 2'b00; result_q <= '0;
                overflow <= 1'b0; error <= 1'b0;
            end else if (done_hit) begin
                result_q <= exe_result;
                overflow <= exe_ovf;
            end else if (timeout_hit) begin
                result_q <= '0;
                overflow <= 1'b0;
                error    <= 1'b1;
            end else begin
                if (key_accept) error <= 1'b0;
`ifdef CALC_CHAIN_EN
                if (chain_load) begin
                    mag_a <= abs_res; sign_a <= result_q[WIDTH-1]; dig_a <= DW'(MAX_DIGITS);
                    op_q  <= op_sel;  mag_b <= '0; sign_b <= 1'b0; dig_b <= '0;
                end
`endif
                if (op_acc) begin
                    op_q <= op_sel;
                    if (state == ENTER_A) begin
                        mag_b <= '0; sign_b <= 1'b0; dig_b <= '0;
                    end
                end else if (neg_acc) begin
                    if (state == ENTER_B) sign_b <= ~sign_b;
                    else                  sign_a <= ~sign_a;
                end else if (dig_rej) begin
                    entry_err <= 1'b1;
                    error     <= 1'b1;
                end else if (dig_acc) begin
                    if (state == SHOW) begin
                        mag_a  <= {{(WIDTH-4){1'b0}}, key_digit};
                        dig_a  <= (key_digit != 4'd0) ? DW'(1) : '0;
                        sign_a <= 1'b0;
                        mag_b  <= '0; sign_b <= 1'b0; dig_b <= '0;
                    end else if (state == ENTER_B) begin
                        mag_b <= new_mag[WIDTH-1:0];
                        if (new_mag != '0) dig_b <= dig_b + 1'b1;
                    end else begin
                        mag_a <= new_mag[WIDTH-1:0];
                        if (new_mag != '0) dig_a <= dig_a + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        display_value = val_a;
        case (state)
            ENTER_B, ISSUE, WAIT: display_value = val_b;
            SHOW:                 display_value = result_q;
            default:              display_value = val_a;
        endcase
    end

    assign exe_start = (state == ISSUE);
    assign busy      = (state == ISSUE) || (state == WAIT);
    assign complete  = (state == SHOW);
    assign exe_op    = op_q;
    assign exe_a     = val_a;
    assign exe_b     = val_b;
endmodule

// File: tb/tb_calc_ctrl_gen.sv
// tb/tb_calc_ctrl_gen.sv - directed table-driven bench for calc_ctrl_gen at default parameters.
module tb_calc_ctrl_gen;
    logic        clk = 1'b0;
    logic        nRST;
    logic [3:0]  key_digit;
    logic        key_valid, op_valid, neg_key, equal_key, clear_key, exe_done, exe_ovf;
    logic [1:0]  op_sel, exe_op;
    logic [15:0] exe_a, exe_b, exe_result, display_value;
    logic        exe_start, busy, complete, overflow, error, entry_err;

    int n_cmp = 0;
    int n_bad = 0;

    calc_ctrl_gen #(.WIDTH(16), .MAX_DIGITS(5), .TIMEOUT(64)) dut (
        .clk(clk), .nRST(nRST), .key_digit(key_digit), .key_valid(key_valid),
        .op_sel(op_sel), .op_valid(op_valid), .neg_key(neg_key), .equal_key(equal_key),
        .clear_key(clear_key), .exe_start(exe_start), .exe_op(exe_op), .exe_a(exe_a),
        .exe_b(exe_b), .exe_done(exe_done), .exe_result(exe_result), .exe_ovf(exe_ovf),
        .display_value(display_value), .busy(busy), .complete(complete),
        .overflow(overflow), .error(error), .entry_err(entry_err)
    );

    always #5 clk = ~clk;

    typedef enum int {K_IDLE, K_DIG, K_OP, K_NEG, K_EQ, K_CLR, K_DONE, K_CLR_DIG} kind_t;

    typedef struct {
        kind_t       k;
        logic [15:0] arg;
        logic        ovf;
        logic [15:0] disp, a, b;
        logic [1:0]  op;
        logic [5:0]  fl;   // {exe_start, busy, complete, entry_err, error, overflow}
    } vec_t;

    vec_t vt[$];

    task automatic add(input kind_t k, input logic [15:0] arg, input logic ovf,
                       input logic [15:0] disp, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] op, input logic [5:0] fl);
        vec_t v;
        v.k = k; v.arg = arg; v.ovf = ovf; v.disp = disp; v.a = a; v.b = b; v.op = op; v.fl = fl;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        key_digit = 4'd0; key_valid = 1'b0; op_sel = 2'b00; op_valid = 1'b0; neg_key = 1'b0;
        equal_key = 1'b0; clear_key = 1'b0; exe_done = 1'b0; exe_result = 16'd0; exe_ovf = 1'b0;
    endtask

    task automatic step(input kind_t k, input logic [15:0] arg, input logic ovf);
        case (k)
            K_DIG:     begin key_valid = 1'b1; key_digit = arg[3:0]; end
            K_OP:      begin op_valid = 1'b1; op_sel = arg[1:0]; end
            K_NEG:     neg_key = 1'b1;
            K_EQ:      equal_key = 1'b1;
            K_CLR:     clear_key = 1'b1;
            K_DONE:    begin exe_done = 1'b1; exe_result = arg; exe_ovf = ovf; end
            K_CLR_DIG: begin clear_key = 1'b1; key_valid = 1'b1; key_digit = arg[3:0]; end
            default:   ;
        endcase
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        nRST = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset display", display_value, 16'd0);
        chk("reset exe_a", exe_a, 16'd0);
        chk("reset exe_b", exe_b, 16'd0);
        chk("reset exe_op", exe_op, 2'd0);
        chk("reset flags", {exe_start, busy, complete, entry_err, error, overflow}, 6'b0);
        nRST = 1'b1;

        // 12 + 34 with a datapath that answers after a few cycles, then a digit leaves SHOW
        add(K_DIG, 1, 0, 1, 1, 0, 0, 6'b000000);
        add(K_DIG, 2, 0, 12, 12, 0, 0, 6'b000000);
        add(K_OP, 0, 0, 0, 12, 0, 0, 6'b000000);
        add(K_DIG, 3, 0, 3, 12, 3, 0, 6'b000000);
        add(K_DIG, 4, 0, 34, 12, 34, 0, 6'b000000);
        add(K_EQ, 0, 0, 34, 12, 34, 0, 6'b110000);
        add(K_IDLE, 0, 0, 34, 12, 34, 0, 6'b010000);
        add(K_IDLE, 0, 0, 34, 12, 34, 0, 6'b010000);
        add(K_DONE, 46, 0, 46, 12, 34, 0, 6'b001000);
        add(K_DIG, 9, 0, 9, 9, 0, 0, 6'b000000);
        // digit limit: 32767 fits, a sixth digit does not
        add(K_CLR, 0, 0, 0, 0, 0, 0, 6'b000000);
        add(K_DIG, 3, 0, 3, 3, 0, 0, 6'b000000);
        add(K_DIG, 2, 0, 32, 32, 0, 0, 6'b000000);
        add(K_DIG, 7, 0, 327, 327, 0, 0, 6'b000000);
        add(K_DIG, 6, 0, 3276, 3276, 0, 0, 6'b000000);
        add(K_DIG, 7, 0, 32767, 32767, 0, 0, 6'b000000);
        add(K_DIG, 1, 0, 32767, 32767, 0, 0, 6'b000110);
        add(K_IDLE, 0, 0, 32767, 32767, 0, 0, 6'b000010);
        // 32768 exceeds the positive range; the next accepted key clears error
        add(K_CLR, 0, 0, 0, 0, 0, 0, 6'b000000);
        add(K_DIG, 3, 0, 3, 3, 0, 0, 6'b000000);
        add(K_DIG, 2, 0, 32, 32, 0, 0, 6'b000000);
        add(K_DIG, 7, 0, 327, 327, 0, 0, 6'b000000);
        add(K_DIG, 6, 0, 3276, 3276, 0, 0, 6'b000000);
        add(K_DIG, 8, 0, 3276, 3276, 0, 0, 6'b000110);
        add(K_NEG, 0, 0, 16'hF334, 16'hF334, 0, 0, 6'b000000);
        // leading zeros are free
        add(K_CLR, 0, 0, 0, 0, 0, 0, 6'b000000);
        add(K_DIG, 0, 0, 0, 0, 0, 0, 6'b000000);
        add(K_DIG, 0, 0, 0, 0, 0, 0, 6'b000000);
        add(K_DIG, 1, 0, 1, 1, 0, 0, 6'b000000);
        add(K_DIG, 2, 0, 12, 12, 0, 0, 6'b000000);
        add(K_DIG, 3, 0, 123, 123, 0, 0, 6'b000000);
        add(K_DIG, 4, 0, 1234, 1234, 0, 0, 6'b000000);
        add(K_DIG, 5, 0, 12345, 12345, 0, 0, 6'b000000);
        add(K_DIG, 0, 0, 12345, 12345, 0, 0, 6'b000110);
        // -5 * 7, result returned in the same cycle as exe_start
        add(K_CLR, 0, 0, 0, 0, 0, 0, 6'b000000);
        add(K_DIG, 5, 0, 5, 5, 0, 0, 6'b000000);
        add(K_NEG, 0, 0, 16'hFFFB, 16'hFFFB, 0, 0, 6'b000000);
        add(K_OP, 2, 0, 0, 16'hFFFB, 0, 2, 6'b000000);
        add(K_DIG, 7, 0, 7, 16'hFFFB, 7, 2, 6'b000000);
        add(K_EQ, 0, 0, 7, 16'hFFFB, 7, 2, 6'b110000);
        add(K_DONE, 16'hFFDD, 1, 16'hFFDD, 16'hFFFB, 7, 2, 6'b001001);
        // clear beats a coincident digit in ENTER_B; reserved op and equal in ENTER_A ignored
        add(K_CLR, 0, 0, 0, 0, 0, 0, 6'b000000);
        add(K_DIG, 4, 0, 4, 4, 0, 0, 6'b000000);
        add(K_OP, 0, 0, 0, 4, 0, 0, 6'b000000);
        add(K_DIG, 5, 0, 5, 4, 5, 0, 6'b000000);
        add(K_CLR_DIG, 7, 0, 0, 0, 0, 0, 6'b000000);
        add(K_DIG, 2, 0, 2, 2, 0, 0, 6'b000000);
        add(K_OP, 3, 0, 2, 2, 0, 0, 6'b000000);
        add(K_DIG, 1, 0, 21, 21, 0, 0, 6'b000000);
        add(K_EQ, 0, 0, 21, 21, 0, 0, 6'b000000);

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].k, vt[i].arg, vt[i].ovf);
            chk($sformatf("v%0d display", i), display_value, vt[i].disp);
            chk($sformatf("v%0d exe_a", i), exe_a, vt[i].a);
            chk($sformatf("v%0d exe_b", i), exe_b, vt[i].b);
            chk($sformatf("v%0d exe_op", i), exe_op, vt[i].op);
            chk($sformatf("v%0d flags", i), {exe_start, busy, complete, entry_err, error, overflow}, vt[i].fl);
        end

        // timeout: 64 cycles in WAIT, SHOW entered at the 65th edge after ISSUE
        begin
            int n;
            step(K_OP, 0, 0);
            step(K_DIG, 1, 0);
            step(K_EQ, 0, 0);
            n = 0;
            while (!complete && n < 200) begin
                step(K_IDLE, 0, 0);
                n++;
            end
            chk("timeout edges", n, 65);
            chk("timeout error", error, 1'b1);
            chk("timeout display", display_value, 16'd0);
            chk("timeout busy", busy, 1'b0);
        end

        // abort in WAIT, late exe_done has no effect
        step(K_CLR, 0, 0);
        chk("clear after timeout error", error, 1'b0);
        step(K_OP, 0, 0);
        step(K_DIG, 3, 0);
        step(K_EQ, 0, 0);
        repeat (10) step(K_IDLE, 0, 0);
        chk("mid-wait busy", busy, 1'b1);
        step(K_CLR, 0, 0);
        chk("abort busy", busy, 1'b0);
        chk("abort display", display_value, 16'd0);
        step(K_DONE, 99, 1);
        chk("late done complete", complete, 1'b0);
        chk("late done display", display_value, 16'd0);
        chk("late done overflow", overflow, 1'b0);

        // operator key in SHOW
        step(K_DIG, 1, 0); step(K_DIG, 2, 0); step(K_OP, 0, 0);
        step(K_DIG, 3, 0); step(K_DIG, 4, 0); step(K_EQ, 0, 0);
        step(K_DONE, 46, 0);
        chk("chain base display", display_value, 16'd46);
        step(K_OP, 1, 0);
`ifdef CALC_CHAIN_EN
        chk("chain complete", complete, 1'b0);
        chk("chain exe_a", exe_a, 16'd46);
        chk("chain exe_op", exe_op, 2'd1);
        step(K_DIG, 6, 0);
        step(K_EQ, 0, 0);
        chk("chain exe_start", exe_start, 1'b1);
        chk("chain issue exe_a", exe_a, 16'd46);
        chk("chain issue exe_b", exe_b, 16'd6);
        step(K_DONE, 40, 0);
`else
        chk("nochain complete", complete, 1'b1);
        chk("nochain display", display_value, 16'd46);
        step(K_NEG, 0, 0);
        chk("nochain neg display", display_value, 16'd46);
        step(K_DIG, 6, 0);
        chk("nochain digit complete", complete, 1'b0);
        chk("nochain digit display", display_value, 16'd6);
`endif

        // asynchronous reset in the middle of an operation
        step(K_CLR, 0, 0);
        step(K_DIG, 5, 0); step(K_OP, 2, 0); step(K_DIG, 3, 0); step(K_EQ, 0, 0);
        step(K_IDLE, 0, 0);
        #2 nRST = 1'b0;
        #1;
        chk("async reset flags", {exe_start, busy, complete, entry_err, error, overflow}, 6'b0);
        chk("async reset display", display_value, 16'd0);
        chk("async reset exe_a", exe_a, 16'd0);
        chk("async reset exe_op", exe_op, 2'd0);
        @(posedge clk);
        #1 nRST = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/calc_ctrl_gen.md
# calc_ctrl_gen

Parametrised calculator sequencer: collects two signed decimal operands and an operator from keypad pulses, issues one operation to an external arithmetic unit over a start/done handshake, and presents the signed result with completion, overflow and error status. It sits between the keypad decoder and the shared add/sub/multiply datapath. It replaces the fixed 16-bit controller and adds:

- generic width and digit limit
- sign entry, clear/abort and an execution timeout
- optional result chaining

## Interface
Parameters:
- WIDTH, 16, operand/result width (two's complement), >= 8
- MAX_DIGITS, 5, max decimal digits accepted per operand
- TIMEOUT, 64, max cycles in WAIT before error, >= 2

Ports:
- clk  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- key_digit  in  4  decimal digit, qualified by key_valid; values 10–15 ignored
- key_valid  in  1  one-cycle digit strobe
- op_sel  in  2  00 add, 01 sub, 10 mul, 11 reserved (ignored), qualified by op_valid
- op_valid  in  1  one-cycle operator strobe
- neg_key  in  1  one-cycle strobe, toggles sign of operand being entered
- equal_key  in  1  one-cycle strobe, request execution
- clear_key  in  1  one-cycle strobe, clear/abort
- exe_start  out  1  one-cycle execute pulse
- exe_op  out  2  operator for datapath
- exe_a, exe_b  out  WIDTH  signed operands
- exe_done  in  1  datapath completion strobe
- exe_result  in  WIDTH  signed result, valid with exe_done
- exe_ovf  in  1  datapath overflow, valid with exe_done
- display_value  out  WIDTH  signed value to show
- busy  out  1  high in ISSUE and WAIT
- complete  out  1  high while in SHOW
- overflow  out  1  latched exe_ovf of last result
- error  out  1  timeout or entry error, cleared by next accepted key
- entry_err  out  1  one-cycle pulse on rejected digit

## Operation
- States: ENTER_A, ENTER_B, ISSUE, WAIT, SHOW.
- Key priority when strobes coincide: clear > equal > op > neg > digit. Only the highest-priority key is acted on in a cycle.
- Digit entry: magnitude = magnitude*10 + digit.
  - A digit is rejected (entry_err pulse, operand unchanged) when MAX_DIGITS are already present or the new magnitude exceeds 2^(WIDTH-1)-1.
  - Leading zeros do not count toward MAX_DIGITS.
- neg_key toggles the sign flag of the current operand. The operand is driven as two's complement of the magnitude when the sign flag is set.
- ENTER_A:
  - op_valid latches the operator and moves to ENTER_B, with operand B = 0 and positive.
  - equal_key is ignored.
- ENTER_B:
  - op_valid overwrites the latched operator.
  - equal_key moves to ISSUE. B = 0 is legal if no digits were entered.
- ISSUE: lasts one cycle. exe_start = 1, and exe_op/exe_a/exe_b are driven. Next state is WAIT.
- WAIT:
  - exe_done: capture exe_result into display_value and exe_ovf into overflow, then go to SHOW.
  - After TIMEOUT cycles without exe_done: error = 1, display_value = 0, go to SHOW.
- SHOW: complete = 1. A digit clears both operands, starts operand A with that digit, and goes to ENTER_A. Handling of op_valid depends on CALC_CHAIN_EN (see Configuration).
- clear_key in any state: operands, sign flags and operator are cleared; error, overflow and complete are cleared; state goes to ENTER_A. In WAIT this aborts the operation, and a later exe_done is ignored.
- display_value:
  - in ENTER_A/ENTER_B it shows the signed operand being entered;
  - in ISSUE/WAIT it holds operand B;
  - in SHOW it shows the result.

## Timing
- Reset values:
  - state ENTER_A;
  - all operands, exe_a, exe_b, exe_op and display_value = 0;
  - exe_start, busy, complete, overflow, error and entry_err = 0.
- Assertion of nRST mid-operation returns immediately to these values.
- equal_key sampled at edge N: exe_start high for cycle N..N+1 only.
- exe_a, exe_b and exe_op are stable from ISSUE until WAIT is left.
- exe_done sampled at edge M: complete and display_value update at edge M. That is one cycle after exe_done for a datapath that asserts exe_done combinationally, otherwise at the same edge.
- exe_done in the same cycle as exe_start is accepted.
- The timeout counter starts at 0 on entry to WAIT. The transition occurs at the edge where the count reaches TIMEOUT.
- Keys other than clear_key are ignored during ISSUE and WAIT.

## Configuration
- CALC_CHAIN_EN defined: op_valid in SHOW loads the shown result (sign and magnitude) as operand A, latches the operator and moves to ENTER_B. After a timeout error, A = 0.
- CALC_CHAIN_EN undefined: op_valid and neg_key in SHOW are ignored. Only a digit or clear_key leaves SHOW.

## Test plan
- Reset then 1,2,add,3,4,equal, with the datapath returning 46 after 3 cycles → exe_start pulse 1 cycle after equal with exe_a=12, exe_b=34, exe_op=00; display_value=46 and complete=1 after exe_done.
- WIDTH=16: digits 3,2,7,6,7 accepted; a 6th digit 1 → entry_err pulse, operand stays 32767. Also 3,2,7,6,8 → last digit rejected.
- 5, neg, mul, 7, equal → exe_a = -5 (0xFFFB), exe_op=10. A datapath result of -35 with exe_ovf=1 → display -35, overflow=1.
- No exe_done for TIMEOUT=64 cycles → SHOW at cycle 64 of WAIT, error=1, display_value=0. Clear in the middle of WAIT → ENTER_A, and a late exe_done is ignored.
- CALC_CHAIN_EN: result 46 shown, then sub, 6, equal → exe_a=46, exe_b=6. Without the macro, the sub in SHOW is ignored and complete stays 1.
- clear_key and key_valid in the same cycle in ENTER_B → clear wins; ENTER_A with operand 0.
